memory_access: RTL and testbench

Memory (MEM) stage of the RV32I pipeline: consumes the registered EX-stage outputs, performs loads and stores on a single-port data-memory bus with a req/ready handshake, and aligns and sign-extends load data. It stalls the upstream pipeline while an access is outstanding and registers the results into the MEM/WB pipeline register that feeds write-back.

---
 rtl/memory_access.sv | 140 ++++++++++++++
 tb/tb_memory_access.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// RV32I MEM stage: drives the data-memory bus, aligns/extends load data and
// registers results into the MEM/WB pipeline register.
//
// state | meaning
// IDLE  | no access outstanding; a zero-wait access completes here
// WAIT  | request issued, holding until the memory returns ready
module memory_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        i_ex_mem_to_reg,
  input  logic        i_ex_reg_wr,
  input  logic        i_ex_mem_rd,
  input  logic        i_ex_mem_wr,
  input  logic        i_ex_result_src,
  input  logic [4:0]  i_ex_reg_destination,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_alu_result,
  input  logic [31:0] i_ex_data2,
  input  logic [31:0] i_ex_pc_plus_4,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_mem_stall,
  output logic        o_mem_mem_to_reg,
  output logic        o_mem_reg_wr,
  output logic        o_mem_result_src,
  output logic [4:0]  o_mem_reg_destination,
  output logic [31:0] o_mem_alu_result,
  output logic [31:0] o_mem_read_data,
  output logic [31:0] o_mem_pc_plus_4,
  output logic        o_mem_misaligned
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state;
  logic        mem_op;
  logic        misaligned;
  logic        access;
  logic        is_load;
  logic [1:0]  offset;
  logic [15:0] lane;
  logic [31:0] load_data;

  assign mem_op  = i_ex_mem_rd | i_ex_mem_wr;
  assign offset  = i_ex_alu_result[1:0];
  assign access  = mem_op & ~misaligned;
  assign is_load = i_ex_mem_rd & ~i_ex_mem_wr;

  always_comb begin
    misaligned = 1'b0;
    if (mem_op) begin
      case (i_ex_funct3[1:0])
        2'b01:   misaligned = offset[0];
        2'b10:   misaligned = |offset;
        default: misaligned = 1'b0;
      endcase
    end
  end

  assign o_mem_stall  = access & ~i_dmem_ready;
  assign o_dmem_req   = access;
  assign o_dmem_we    = i_ex_mem_wr;
  assign o_dmem_addr  = {i_ex_alu_result[31:2], 2'b00};

  always_comb begin
    o_dmem_be = 4'b0000;
    if (access) begin
      case (i_ex_funct3[1:0])
        2'b00:   o_dmem_be = 4'b0001 << offset;
        2'b01:   o_dmem_be = 4'b0011 << offset;
        default: o_dmem_be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (i_ex_funct3[1:0])
      2'b00:   o_dmem_wdata = {4{i_ex_data2[7:0]}};
      2'b01:   o_dmem_wdata = {2{i_ex_data2[15:0]}};
      default: o_dmem_wdata = i_ex_data2;
    endcase
  end

  // Only the low 16 bits of the shifted word are ever needed (byte or half).
  assign lane = 16'(i_dmem_rdata >> {offset, 3'b000});

  always_comb begin
    case (i_ex_funct3)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'h0, lane[7:0]};
      3'b101:  load_data = {16'h0, lane[15:0]};
      default: load_data = i_dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      o_mem_mem_to_reg      <= 1'b0;
      o_mem_reg_wr          <= 1'b0;
      o_mem_result_src      <= 1'b0;
      o_mem_reg_destination <= 5'd0;
      o_mem_alu_result      <= 32'h0;
      o_mem_read_data       <= 32'h0;
      o_mem_pc_plus_4       <= 32'h0;
      o_mem_misaligned      <= 1'b0;
    end else if (clk_en) begin
      case (state)
        IDLE:    if (access & ~i_dmem_ready) state <= WAIT;
        WAIT:    if (i_dmem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (o_mem_stall) begin
        o_mem_reg_wr     <= 1'b0;
        o_mem_misaligned <= 1'b0;
      end else begin
        o_mem_mem_to_reg      <= i_ex_mem_to_reg;
        o_mem_reg_wr          <= i_ex_reg_wr & ~misaligned;
        o_mem_result_src      <= i_ex_result_src;
        o_mem_reg_destination <= i_ex_reg_destination;
        o_mem_alu_result      <= i_ex_alu_result;
        o_mem_read_data       <= (access && is_load) ? load_data : 32'h0;
        o_mem_pc_plus_4       <= i_ex_pc_plus_4;
        o_mem_misaligned      <= misaligned;
      end
    end
  end

  // Upstream must keep presenting the access for as long as we are waiting on it.
  hold_while_waiting: assert property (@(posedge clk) disable iff (!rst_n)
    (clk_en && state == WAIT) |-> access);

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: table of zero-wait vectors plus hand-built
// wait-state, clock-enable and reset-mid-wait sequences, scored via a queue.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n, clk_en;
  logic        ex_m2r, ex_reg_wr, ex_rd_en, ex_wr_en, ex_rsrc;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_f3;
  logic [31:0] ex_alu, ex_data2, ex_pc4;
  logic        dmem_req, dmem_we, dmem_ready, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_m2r, mem_reg_wr, mem_rsrc, mem_mis;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu, mem_rdata, mem_pc4;

  int errors = 0;
  int checks = 0;

  memory_access dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .i_ex_mem_to_reg(ex_m2r), .i_ex_reg_wr(ex_reg_wr), .i_ex_mem_rd(ex_rd_en),
    .i_ex_mem_wr(ex_wr_en), .i_ex_result_src(ex_rsrc),
    .i_ex_reg_destination(ex_rd), .i_ex_funct3(ex_f3),
    .i_ex_alu_result(ex_alu), .i_ex_data2(ex_data2), .i_ex_pc_plus_4(ex_pc4),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_be(dmem_be), .o_dmem_wdata(dmem_wdata),
    .i_dmem_ready(dmem_ready), .i_dmem_rdata(dmem_rdata),
    .o_mem_stall(mem_stall),
    .o_mem_mem_to_reg(mem_m2r), .o_mem_reg_wr(mem_reg_wr),
    .o_mem_result_src(mem_rsrc), .o_mem_reg_destination(mem_rd),
    .o_mem_alu_result(mem_alu), .o_mem_read_data(mem_rdata),
    .o_mem_pc_plus_4(mem_pc4), .o_mem_misaligned(mem_mis)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd_en, wr_en, reg_wr;
    logic [2:0]  f3;
    logic [31:0] addr, data2, rdata;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] wdata, rdat_exp;
    logic        wb_reg_wr, wb_mis;
  } vec_t;

  typedef struct packed {
    logic        reg_wr, m2r, rsrc, mis;
    logic [4:0]  rd;
    logic [31:0] alu, rdat, pc4;
  } wb_t;

  wb_t  model;
  wb_t  sb[$];
  vec_t tbl[14];
  vec_t idle_v, lw_wait, lw_after;

  function automatic vec_t mk(logic rd_en, logic wr_en, logic reg_wr, logic [2:0] f3,
                              logic [31:0] addr, logic [31:0] data2, logic [31:0] rdata,
                              logic req, logic we, logic [3:0] be, logic [31:0] wdata,
                              logic [31:0] rdat_exp, logic wb_reg_wr, logic wb_mis);
    vec_t v;
    v.rd_en = rd_en; v.wr_en = wr_en; v.reg_wr = reg_wr; v.f3 = f3;
    v.addr = addr; v.data2 = data2; v.rdata = rdata;
    v.req = req; v.we = we; v.be = be; v.wdata = wdata;
    v.rdat_exp = rdat_exp; v.wb_reg_wr = wb_reg_wr; v.wb_mis = wb_mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_wb(input string tag, input wb_t e);
    check({tag, ".reg_wr"}, 32'(mem_reg_wr), 32'(e.reg_wr));
    check({tag, ".misaligned"}, 32'(mem_mis), 32'(e.mis));
    check({tag, ".mem_to_reg"}, 32'(mem_m2r), 32'(e.m2r));
    check({tag, ".result_src"}, 32'(mem_rsrc), 32'(e.rsrc));
    check({tag, ".rd"}, 32'(mem_rd), 32'(e.rd));
    check({tag, ".alu"}, mem_alu, e.alu);
    check({tag, ".read_data"}, mem_rdata, e.rdat);
    check({tag, ".pc4"}, mem_pc4, e.pc4);
  endtask

  // Drive one cycle of EX inputs, check the bus side, then score MEM/WB after the edge.
  task automatic apply(input string tag, input vec_t v, input logic rdy, input logic en,
                       input logic exp_stall);
    wb_t e;
    ex_rd_en = v.rd_en; ex_wr_en = v.wr_en; ex_reg_wr = v.reg_wr;
    ex_m2r = v.rd_en; ex_rsrc = v.wr_en; ex_rd = v.addr[4:0] ^ 5'h15;
    ex_f3 = v.f3; ex_alu = v.addr; ex_data2 = v.data2; ex_pc4 = v.addr + 32'd4;
    dmem_rdata = v.rdata; dmem_ready = rdy; clk_en = en;
    #1;
    check({tag, ".req"}, 32'(dmem_req), 32'(v.req));
    check({tag, ".we"}, 32'(dmem_we), 32'(v.we));
    check({tag, ".be"}, 32'(dmem_be), 32'(v.be));
    check({tag, ".wdata"}, dmem_wdata, v.wdata);
    check({tag, ".addr"}, dmem_addr, {v.addr[31:2], 2'b00});
    check({tag, ".stall"}, 32'(mem_stall), 32'(exp_stall));
    if (en) begin
      if (exp_stall) begin
        model.reg_wr = 1'b0;
        model.mis    = 1'b0;
      end else begin
        model.reg_wr = v.wb_reg_wr; model.mis = v.wb_mis;
        model.m2r = v.rd_en; model.rsrc = v.wr_en; model.rd = v.addr[4:0] ^ 5'h15;
        model.alu = v.addr; model.rdat = v.rdat_exp; model.pc4 = v.addr + 32'd4;
      end
    end
    sb.push_back(model);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s.scoreboard: got empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      compare_wb(tag, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_v   = mk(0,0,0,3'b000,32'h0,32'h0,32'h0, 0,0,4'h0,32'h0, 32'h0,0,0);
    lw_wait  = mk(1,0,1,3'b010,32'h110,32'h0,32'hA1B2C3D4, 1,0,4'hF,32'h0, 32'hA1B2C3D4,1,0);
    lw_after = mk(1,0,1,3'b010,32'h120,32'h0,32'h0BADF00D, 1,0,4'hF,32'h0, 32'h0BADF00D,1,0);
    tbl[0]  = mk(0,1,0,3'b010,32'h100,32'hDEADBEEF,32'h0, 1,1,4'hF,32'hDEADBEEF, 32'h0,0,0);
    tbl[1]  = mk(1,0,1,3'b010,32'h100,32'h0,32'hDEADBEEF, 1,0,4'hF,32'h0, 32'hDEADBEEF,1,0);
    tbl[2]  = mk(1,0,1,3'b000,32'h103,32'h0,32'h80FF7F01, 1,0,4'h8,32'h0, 32'hFFFFFF80,1,0);
    tbl[3]  = mk(1,0,1,3'b100,32'h103,32'h0,32'h80FF7F01, 1,0,4'h8,32'h0, 32'h00000080,1,0);
    tbl[4]  = mk(1,0,1,3'b001,32'h102,32'h0,32'h80FF7F01, 1,0,4'hC,32'h0, 32'hFFFF80FF,1,0);
    tbl[5]  = mk(1,0,1,3'b101,32'h100,32'h0,32'h80FF7F01, 1,0,4'h3,32'h0, 32'h00007F01,1,0);
    tbl[6]  = mk(1,0,1,3'b000,32'h101,32'h0,32'h80FF7F01, 1,0,4'h2,32'h0, 32'h0000007F,1,0);
    tbl[7]  = mk(0,1,0,3'b000,32'h202,32'h12345678,32'h0, 1,1,4'h4,32'h78787878, 32'h0,0,0);
    tbl[8]  = mk(0,1,0,3'b001,32'h202,32'h12345678,32'h0, 1,1,4'hC,32'h56785678, 32'h0,0,0);
    tbl[9]  = mk(0,0,1,3'b001,32'h00012345,32'h55,32'hFFFFFFFF, 0,0,4'h0,32'h00550055, 32'h0,1,0);
    tbl[10] = mk(1,0,1,3'b001,32'h101,32'h0,32'h80FF7F01, 0,0,4'h0,32'h0, 32'h0,0,1);
    tbl[11] = mk(1,0,1,3'b010,32'h104,32'h0,32'h13579BDF, 1,0,4'hF,32'h0, 32'h13579BDF,1,0);
    tbl[12] = mk(0,1,0,3'b010,32'h102,32'hA5A5A5A5,32'h0, 0,1,4'h0,32'hA5A5A5A5, 32'h0,0,1);
    tbl[13] = mk(1,0,1,3'b101,32'h106,32'h0,32'hBEEF1234, 1,0,4'hC,32'h0, 32'h0000BEEF,1,0);

    rst_n = 1'b0; clk_en = 1'b1; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    ex_m2r = 0; ex_reg_wr = 0; ex_rd_en = 0; ex_wr_en = 0; ex_rsrc = 0;
    ex_rd = 0; ex_f3 = 0; ex_alu = 0; ex_data2 = 0; ex_pc4 = 0;
    model = '0;
    #3;
    compare_wb("reset", '0);
    check("reset.stall", 32'(mem_stall), 32'h0);
    check("reset.fsm", 32'(dut.state), 32'h0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++)
      apply($sformatf("vec%0d", i), tbl[i], tbl[i].req, 1'b1, 1'b0);

    // LW with three wait states: three bubbles, then the data.
    for (int k = 0; k < 3; k++) begin
      apply($sformatf("wait%0d", k), lw_wait, 1'b0, 1'b1, 1'b1);
      check($sformatf("wait%0d.fsm", k), 32'(dut.state), 32'h1);
    end
    apply("wait_done", lw_wait, 1'b1, 1'b1, 1'b0);
    check("wait_done.fsm", 32'(dut.state), 32'h0);

    // Gated clock: the register must hold the previous result.
    apply("gated", tbl[9], 1'b0, 1'b0, 1'b0);
    apply("ungated", tbl[9], 1'b0, 1'b1, 1'b0);

    // Reset while waiting, then a late ready must be ignored.
    apply("pre_rst", lw_wait, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    ex_rd_en = 0; ex_wr_en = 0; ex_reg_wr = 0; ex_m2r = 0; ex_rsrc = 0;
    ex_rd = 0; ex_f3 = 0; ex_alu = 0; ex_data2 = 0; ex_pc4 = 0;
    #1;
    model = '0;
    compare_wb("rst_mid", model);
    check("rst_mid.fsm", 32'(dut.state), 32'h0);
    check("rst_mid.req", 32'(dmem_req), 32'h0);
    check("rst_mid.stall", 32'(mem_stall), 32'h0);
    #4;
    rst_n = 1'b1;
    apply("late_ready", idle_v, 1'b1, 1'b1, 1'b0);
    check("late_ready.fsm", 32'(dut.state), 32'h0);
    apply("post_rst_lw", lw_after, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
